// File: rtl/flip_selector_stream.sv
// WalkSAT flip selector with a handshake interface. It collects NSAT literal beats for one
// unsatisfied clause, then picks the literal to flip: zero-break, random walk, or min-break.
module flip_selector_stream #(
    parameter int          MAX_CLAUSES_PER_VARIABLE = 20,
    parameter int          NSAT                     = 3,
    parameter logic [31:0] P                        = 32'h6E147AE0
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start_i,
    input  logic                                              abort_i,
    input  logic                                              lit_valid_i,
    output logic                                              lit_ready_o,
    input  logic                                              lit_present_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0]               clause_broken_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0]               mask_bits_i,
    input  logic [31:0]                                       random_i,
    output logic                                              busy_o,
    output logic                                              result_valid_o,
    input  logic                                              result_ready_i,
    output logic [$clog2(NSAT)-1:0]                           selected_o,
    output logic [$clog2(MAX_CLAUSES_PER_VARIABLE+1)-1:0]     break_value_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0]               clause_broken_bits_o,
    output logic [1:0]                                        mode_o
);

    localparam int MC       = MAX_CLAUSES_PER_VARIABLE;
    localparam int MCB      = $clog2(MC + 1);
    localparam int NB       = $clog2(NSAT);
    localparam int CW       = $clog2(NSAT + 1);
    localparam int RAND_LSB = 16;

    localparam logic [1:0] MODE_ZERO = 2'b00;
    localparam logic [1:0] MODE_WALK = 2'b01;
    localparam logic [1:0] MODE_MIN  = 2'b10;
    localparam logic [1:0] MODE_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SELECT  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]  cnt_q;
    logic [MC-1:0]  slot_bits [NSAT];
    logic [MCB-1:0] slot_bv   [NSAT];
    logic [NSAT-1:0] slot_pres;

    logic           beat_accept;
    logic           last_beat;
    logic [MC-1:0]  beat_bits;
    logic [MCB-1:0] beat_bv;

    logic [1:0]     sel_mode;
    logic [NB-1:0]  sel_idx;
    logic [MCB-1:0] sel_bv;
    logic [MC-1:0]  sel_bits;

    function automatic logic [MCB-1:0] popcount(input logic [MC-1:0] v);
        logic [MCB-1:0] c;
        c = '0;
        for (int i = 0; i < MC; i++) begin
            c = c + MCB'(v[i]);
        end
        return c;
    endfunction

    assign beat_bits   = clause_broken_i & mask_bits_i;
    assign beat_bv     = popcount(beat_bits);
    assign beat_accept = lit_valid_i && lit_ready_o;
    assign last_beat   = beat_accept && (cnt_q == CW'(NSAT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i) state_d = COLLECT;
                COLLECT: if (last_beat) state_d = SELECT;
                SELECT:  state_d = DONE;
                DONE:    if (result_ready_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake and status outputs
    always_comb begin
        lit_ready_o    = 1'b0;
        busy_o         = 1'b1;
        result_valid_o = 1'b0;
        case (state_q)
            IDLE:    busy_o = 1'b0;
            COLLECT: lit_ready_o = 1'b1;
            DONE:    result_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Selection heuristic evaluated over the collected slots
    always_comb begin
        logic any_pres;
        logic zero_found;
        logic walk_found;
        logic min_found;
        int   zero_idx;
        int   walk_idx;
        int   min_idx;
        int   chosen;
        int   r_int;
        int   idx;
        logic [MCB-1:0] min_bv;

        any_pres   = 1'b0;
        zero_found = 1'b0;
        walk_found = 1'b0;
        min_found  = 1'b0;
        zero_idx   = 0;
        walk_idx   = 0;
        min_idx    = 0;
        chosen     = 0;
        idx        = 0;
        min_bv     = '0;

        for (int i = 0; i < NSAT; i++) begin
            if (slot_pres[i]) begin
                any_pres = 1'b1;
                if (!zero_found && slot_bv[i] == '0) begin
                    zero_found = 1'b1;
                    zero_idx   = i;
                end
                if (!min_found || slot_bv[i] < min_bv) begin
                    min_found = 1'b1;
                    min_idx   = i;
                    min_bv    = slot_bv[i];
                end
            end
        end

        // Random start index, folded back into range with a single subtraction
        r_int = int'(random_i[RAND_LSB +: NB]);
        if (r_int >= NSAT) begin
            r_int = r_int - NSAT;
        end
        for (int k = 0; k < NSAT; k++) begin
            idx = r_int + k;
            if (idx >= NSAT) begin
                idx = idx - NSAT;
            end
            for (int j = 0; j < NSAT; j++) begin
                if (!walk_found && j == idx && slot_pres[j]) begin
                    walk_found = 1'b1;
                    walk_idx   = j;
                end
            end
        end

        sel_mode = MODE_NONE;
        if (!any_pres) begin
            sel_mode = MODE_NONE;
        end else if (zero_found) begin
            sel_mode = MODE_ZERO;
            chosen   = zero_idx;
        end else if (random_i < P) begin
            sel_mode = MODE_WALK;
            chosen   = walk_idx;
        end else begin
            sel_mode = MODE_MIN;
            chosen   = min_idx;
        end

        sel_idx  = '1;
        sel_bv   = '0;
        sel_bits = '0;
        for (int j = 0; j < NSAT; j++) begin
            if (any_pres && j == chosen) begin
                sel_idx  = NB'(j);
                sel_bv   = slot_bv[j];
                sel_bits = slot_bits[j];
            end
        end
    end

    // Literal slots, beat counter and registered result
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q                <= '0;
            slot_pres            <= '0;
            selected_o           <= '1;
            mode_o               <= MODE_NONE;
            break_value_o        <= '0;
            clause_broken_bits_o <= '0;
            for (int i = 0; i < NSAT; i++) begin
                slot_bits[i] <= '0;
                slot_bv[i]   <= '0;
            end
        end else if (abort_i) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cnt_q <= '0;
                    end
                end
                COLLECT: begin
                    if (beat_accept) begin
                        for (int i = 0; i < NSAT; i++) begin
                            if (cnt_q == CW'(i)) begin
                                slot_bits[i] <= beat_bits;
                                slot_bv[i]   <= beat_bv;
                                slot_pres[i] <= lit_present_i;
                            end
                        end
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SELECT: begin
                    selected_o           <= sel_idx;
                    mode_o               <= sel_mode;
                    break_value_o        <= sel_bv;
                    clause_broken_bits_o <= sel_bits;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/flip_selector_stream.md
Name: flip_selector_stream

Overview:
- Parametrised successor to the WalkSAT variable flip selector, with a handshake interface.
- Accepts one literal per beat for the chosen unsatisfied clause. Each beat carries that literal's clause-broken bits and mask bits.
- For each literal, counts the break value and stores it with the broken-clause bits.
- After all NSAT literals are in, applies the probabilistic heuristic: zero-break greedy, then random walk with probability P, then minimum break.
- Sits between the clause fetch controller and the variable flip/update stage.

Parameters:
- MAX_CLAUSES_PER_VARIABLE, 20: clause slots per literal (MC); must be >= 1.
- NSAT, 3: literals per clause; must be >= 2.
- P, 32'h6E147AE0: random-walk threshold; random walk when random_i < P (unsigned).
- Derived: MCB = $clog2(MC+1), so a full count of MC fits. NB = $clog2(NSAT).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  begin a selection; sampled only in IDLE.
- abort_i  in  1  cancel the current selection; takes effect from any state.
- lit_valid_i  in  1  a literal beat is present.
- lit_ready_o  out  1  ready for a literal beat; high only in COLLECT.
- lit_present_i  in  1  the literal is a real candidate (0 = padding, or the literal is excluded).
- clause_broken_i  in  MC  per-clause "would break" bits.
- mask_bits_i  in  MC  per-clause valid mask.
- random_i  in  32  LFSR value, sampled in the SELECT cycle.
- busy_o  out  1  state is not IDLE.
- result_valid_o  out  1  result held, high in DONE.
- result_ready_i  in  1  consumer accepts the result.
- selected_o  out  NB  index of the chosen literal.
- break_value_o  out  MCB  break value of the chosen literal.
- clause_broken_bits_o  out  MC  masked broken bits of the chosen literal.
- mode_o  out  2  how the choice was made: 00 zero-break, 01 random walk, 10 min-break, 11 no candidate.

Behaviour:
- Reset (synchronous, active-high) puts the block in IDLE. Output reset values: selected_o all ones, mode_o = 11, break_value_o = 0, clause_broken_bits_o = 0, result_valid_o = 0, lit_ready_o = 0, busy_o = 0. Literal counter and slot registers clear to 0.
- FSM states: IDLE, COLLECT, SELECT, DONE.
- IDLE: start_i = 1 moves to COLLECT and sets the counter to 0.
- COLLECT: a beat is accepted when lit_valid_i && lit_ready_o.
  - On accept, slot[cnt] stores: bits = clause_broken_i & mask_bits_i, bv = popcount(bits), pres = lit_present_i. Then cnt increments.
  - Popcount is combinational, with zero latency from the beat.
  - On the beat that makes cnt reach NSAT: go to SELECT, lit_ready_o drops on the next cycle, and the counter does not wrap.
  - lit_valid_i low causes a stall with no state change.
- SELECT: one cycle. Compute the following from the slots, register the result, then go to DONE.
  - No slot present: mode 11, selected_o all ones, break_value_o = 0, clause_broken_bits_o = 0.
  - Else, some present slot has bv == 0: mode 00, choose the lowest such index.
  - Else, random_i < P: mode 01.
    - r = random_i[16 +: NB]; if r >= NSAT, subtract NSAT (one subtraction suffices).
    - Choose the first present slot scanning cyclically from r upward.
  - Else: mode 10, choose the present slot with minimum bv; ties go to the lowest index.
  - For modes 00, 01 and 10, break_value_o and clause_broken_bits_o come from the chosen slot.
- DONE: result_valid_o = 1. All result outputs are held stable until result_ready_i = 1, then go to IDLE. A new start_i is honoured at the earliest on the cycle after returning to IDLE.
- Latency: NSAT accepted beats, then 1 SELECT cycle. result_valid_o rises on the cycle after SELECT, i.e. NSAT+1 cycles after the first beat with no stalls.
- abort_i:
  - Has priority over every other transition except reset.
  - On the next edge the state is IDLE, cnt = 0 and result_valid_o = 0.
  - Result outputs keep their previous values; mode_o is not cleared.
- start_i outside IDLE is ignored. result_ready_i outside DONE is ignored.
- Reset asserted mid-COLLECT or in DONE gives the full reset values on the next edge, and any partial slots are discarded.

Test Plan:
- NSAT=3, MC=20. bits per beat: lit0 = 0x3 (bv 2), lit1 = 0x0 (bv 0), lit2 = 0x1 (bv 1), all present -> mode 00, selected 1, break_value 0, result_valid on cycle 4 after the first beat.
- Masked broken bits (clause_broken_i & mask_bits_i): 0x7, 0x3, 0xF (bv 3, 2, 4), random_i = 32'hFFFFFFFF (>= P) -> mode 10, selected 1, bits 0x3. Repeat with bv 2, 2, 4 -> selected 0 (tie goes to the lowest index).
- Same bv 3, 2, 4, random_i = 32'h00030000: r = 3, reduced to 0 -> mode 01, selected 0. With lit0 not present -> selected 1.
- All three literals lit_present_i = 0 -> mode 11, selected_o = 2'b11, break_value 0, clause_broken_bits 0.
- Mask all ones, clause_broken_i all ones (MC=20) -> that literal's bv = 20 with no overflow. Stall lit_valid_i low for 5 cycles mid-COLLECT -> counter holds and the result is unchanged.
- abort_i after 2 beats -> IDLE next cycle, result_valid stays 0. reset asserted in DONE -> selected_o = 2'b11, mode_o = 11, result_valid_o = 0 on the next edge. Hold result_ready_i low for 10 cycles in DONE -> outputs stable.
